fetch_frontend: RTL

//  Parametrised instruction-fetch front end: owns the PC, issues single-outstanding

---
 rtl/fetch_frontend.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_frontend.sv
// Instruction-fetch front end: PC owner, single-outstanding I-side reads,
// and an IQ_DEPTH-entry buffer of {instr, pc} with epoch-safe flush.
module fetch_frontend #(
    parameter int              WIDTH    = 32,
    parameter int              IQ_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h60)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_mem_resp,
    input  logic [WIDTH-1:0]              i_mem_rdata,
    output logic                          i_mem_read,
    output logic [WIDTH-1:0]              i_mem_address,
    input  logic                          pred_valid,
    input  logic [WIDTH-1:0]              pred_target,
    input  logic                          flush_valid,
    input  logic [WIDTH-1:0]              flush_pc,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_instr,
    output logic [WIDTH-1:0]              out_pc,
    output logic                          iq_empty,
    output logic                          iq_full,
    output logic [$clog2(IQ_DEPTH+1)-1:0] iq_count
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = $clog2(IQ_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] pc_n;
    logic             enq;
    logic             deq;
    logic             credit;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] instr_q [IQ_DEPTH];
    logic [WIDTH-1:0] pc_q    [IQ_DEPTH];

    assign credit        = count < CW'(IQ_DEPTH);
    assign deq           = out_ready && (count != '0);
    assign i_mem_read    = state != IDLE;
    assign i_mem_address = fetch_pc;
    assign out_valid     = count != '0;
    assign iq_empty      = count == '0;
    assign iq_full       = count == CW'(IQ_DEPTH);
    assign iq_count      = count;
    assign out_instr     = instr_q[head];
    assign out_pc        = pc_q[head];

    // Fetch FSM next state, next PC and enqueue decision; flush dominates.
    always_comb begin
        state_n = state;
        pc_n    = fetch_pc;
        enq     = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush_valid) begin
                    pc_n = flush_pc;
                end else if (credit) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (flush_valid) begin
                    pc_n    = flush_pc;
                    state_n = i_mem_resp ? IDLE : DROP;
                end else if (i_mem_resp) begin
                    enq     = 1'b1;
                    pc_n    = pred_valid ? pred_target
                                         : fetch_pc + WIDTH'(4);
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (flush_valid) begin
                    pc_n = flush_pc;
                end
                if (i_mem_resp) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= pc_n;
        end
    end

    // Buffer pointers and occupancy; flush empties the buffer outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // Buffer storage, written at tail on each accepted live response.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[tail] <= i_mem_rdata;
            pc_q[tail]    <= fetch_pc;
        end
    end

endmodule
